chocorrol_pipe: RTL and testbench
=================================

CHOCORROL_PIPE -- requirements
Module: chocorrol_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width (legal range 8..64).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-address width; the register file holds 2^ADDR_W entries.
REQ-003 SHALL derive localparam INSTR_W = 3*ADDR_W+5; the default value is 20.
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state updates occur on the rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port INSTRUCCION, input, INSTR_W bits: {MC[1:0], OP1, ALUC[2:0], OP2, MB}, most significant field first.
REQ-007 SHALL have port IN_VALID, input, 1 bit: INSTRUCCION is presented.
REQ-008 SHALL have port IN_READY, output, 1 bit: the block accepts the presented instruction.
REQ-009 SHALL have port RESULTADO, output, DATA_W bits: the result of the retired instruction.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: RESULTADO is valid.
REQ-011 SHALL have port OUT_READY, input, 1 bit: the consumer takes RESULTADO.
REQ-012 SHALL have ports CERO and ACARREO, outputs, 1 bit each: result-zero flag and carry/borrow flag.

Function
REQ-013 SHALL accept an instruction only on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-014 SHALL implement a 2-stage pipeline:
- S1 registers the decoded fields and reads REG[OP1] and REG[OP2].
- S2 computes the ALU result and registers RESULTADO, CERO and ACARREO.
REQ-015 SHALL assert OUT_VALID with the result on the second rising edge after acceptance when not stalled, with a sustained throughput of one instruction per cycle.
REQ-016 SHALL decode MC as follows:
- 00: no write-back; RESULTADO = 0.
- 01: REG[MB] <= {OP1,ALUC,OP2} zero-extended, or truncated to DATA_W if wider; RESULTADO = that value.
- 10: REG[MB] <= ALU(REG[OP1], REG[OP2]); RESULTADO = ALU result.
- 11: ALU result to RESULTADO only, with no write-back.
REQ-017 SHALL decode ALUC as follows: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 pass A, 110 SUB (A-B), 111 unsigned A<B giving 1 or 0, zero-extended.
REQ-018 SHALL compute all arithmetic modulo 2^DATA_W.
REQ-019 SHALL set ACARREO as follows:
- ADD: carry-out.
- SUB: 1 when A<B (borrow).
- all other operations: 0.
REQ-020 SHALL set CERO = 1 exactly when RESULTADO == 0, including for MC=00.
REQ-021 SHALL perform the register write at the same rising edge on which the instruction's result is registered into RESULTADO.
REQ-022 SHALL forward the S2 result to S1 when an S2 instruction with MC in {01,10} writes MB equal to S1's OP1 and/or OP2, so that back-to-back dependent instructions see the new value.
REQ-023 SHALL hold S2, RESULTADO, the flags and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0; no register write SHALL repeat during the hold.
REQ-024 SHALL drive IN_READY = !(S1 occupied and S2 stalled), a combinational function of state and OUT_READY, so that no instruction is lost or duplicated.
REQ-025 SHALL, when S2 is stalled and S1 is occupied, hold S1, and S1's forwarding SHALL remain correct after the stall releases.
REQ-026 SHALL deassert OUT_VALID on the first edge where OUT_READY=1 and no new result enters S2.
REQ-027 SHALL, when MB equals OP1 or OP2 within a single instruction, read the old value and write the new value.

Reset
REQ-028 SHALL, while RST_N=0, immediately clear all registers, both pipeline stages, RESULTADO, CERO, ACARREO and OUT_VALID to 0, independent of CLK.
REQ-029 SHALL hold IN_READY = 0 while RST_N=0 and drive it to 1 on the first cycle after release.
REQ-030 SHALL discard in-flight instructions on reset mid-operation; no write-back from them SHALL occur.

Verification
REQ-031 SHALL cover load and dependent ADD: issue back-to-back MC=01 R1<-7, MC=01 R2<-5, MC=10 ADD R3=R1+R2 with OUT_READY=1 -> results 7, 5, 12 on consecutive cycles; the first result appears 2 edges after the first acceptance; CERO=0.
REQ-032 SHALL cover SUB borrow: with R2=5 and R1=7, MC=11 SUB R2-R1 -> RESULTADO=0xFFFFFFFE, ACARREO=1, and no register changes.
REQ-033 SHALL cover SLT and NOR: with R1=3, R2=4, SLT R1,R2 -> 1 and SLT R2,R1 -> 0; with R1=2, R2=1, NOR -> 0xFFFFFFFC.
REQ-034 SHALL cover backpressure: stream 4 loads and hold OUT_READY=0 for 3 cycles -> IN_READY=0 after 2 accepts, RESULTADO held constant, all 4 results delivered in order exactly once.
REQ-035 SHALL cover reset mid-stream: assert RST_N=0 asynchronously with 2 instructions in flight -> OUT_VALID=0 at once; after release, MC=11 pass R1 returns 0.
REQ-036 SHALL cover DATA_W=16: ADD 0xFFFF+0x0001 -> RESULTADO=0, CERO=1, ACARREO=1.

Source files
------------

// File: rtl/chocorrol_pipe.sv
`default_nettype none
// ============================================================================
// Module      : chocorrol_pipe
// Description : Two-stage in-order instruction pipeline around a small
//               register file and an 8-function ALU.
//
//               Instruction word, most significant field first:
//                   {MC[1:0], OP1[ADDR_W], ALUC[2:0], OP2[ADDR_W], MB[ADDR_W]}
//
//               Stage S1 holds the decoded fields together with the operand
//               values read at acceptance. Stage S2 is the result register
//               (RESULTADO / CERO / ACARREO / OUT_VALID). The register-file
//               write of an instruction happens on the same edge its result
//               enters S2.
//
// Ports       : CLK          in   clock, rising-edge active
//               RST_N        in   asynchronous active-low reset
//               INSTRUCCION  in   instruction word (INSTR_W bits)
//               IN_VALID     in   INSTRUCCION is presented
//               IN_READY     out  instruction is accepted this cycle
//               RESULTADO    out  result of the retired instruction
//               OUT_VALID    out  RESULTADO/CERO/ACARREO are valid
//               OUT_READY    in   consumer takes the result
//               CERO         out  RESULTADO == 0
//               ACARREO      out  carry (ADD) / borrow (SUB), else 0
//
// Revision    : 1.0  initial release
// ============================================================================
module chocorrol_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int INSTR_W = 3 * ADDR_W + 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [INSTR_W-1:0] INSTRUCCION,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [DATA_W-1:0]  RESULTADO,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic               CERO,
    output logic               ACARREO
);

    localparam int NREGS = 1 << ADDR_W;
    localparam int IMM_W = 2 * ADDR_W + 3;

    localparam logic [1:0] MC_NONE = 2'b00;
    localparam logic [1:0] MC_LOAD = 2'b01;
    localparam logic [1:0] MC_ALUW = 2'b10;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [1:0]        mc_in;
    logic [ADDR_W-1:0] op1_in;
    logic [2:0]        aluc_in;
    logic [ADDR_W-1:0] op2_in;
    logic [ADDR_W-1:0] mb_in;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_in;

    assign mc_in   = INSTRUCCION[INSTR_W-1 -: 2];
    assign op1_in  = INSTRUCCION[3*ADDR_W+2 -: ADDR_W];
    assign aluc_in = INSTRUCCION[2*ADDR_W+2 -: 3];
    assign op2_in  = INSTRUCCION[2*ADDR_W-1 -: ADDR_W];
    assign mb_in   = INSTRUCCION[ADDR_W-1:0];
    // {OP1, ALUC, OP2} used as the load immediate
    assign imm_raw = INSTRUCCION[3*ADDR_W+2 : ADDR_W];

    // Immediate is zero-extended when narrower than the datapath and
    // truncated to its low DATA_W bits when wider.
    generate
        if (IMM_W >= DATA_W) begin : g_imm_trunc
            assign imm_in = imm_raw[DATA_W-1:0];
        end else begin : g_imm_zext
            assign imm_in = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NREGS];

    logic              s1_valid;
    logic [1:0]        s1_mc;
    logic [2:0]        s1_aluc;
    logic [ADDR_W-1:0] s1_mb;
    logic [DATA_W-1:0] s1_imm;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;     // S2 holds an unconsumed result
    logic advance;   // S2 may load a new result (or drain) this edge
    logic accept;
    logic wb_en;     // register write happening at this edge

    assign stall    = OUT_VALID && !OUT_READY;
    assign advance  = !stall;
    // Gated by RST_N so nothing can be accepted while reset is asserted.
    assign IN_READY = RST_N && !(s1_valid && stall);
    assign accept   = IN_VALID && IN_READY;
    assign wb_en    = s1_valid && advance && ((s1_mc == MC_LOAD) || (s1_mc == MC_ALUW));

    // ------------------------------------------------------------------
    // ALU on the S1 operands
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (s1_aluc)
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_ADD:  {alu_carry, alu_res} = {1'b0, s1_a} + {1'b0, s1_b};
            OP_XOR:  alu_res = s1_a ^ s1_b;
            OP_NOR:  alu_res = ~(s1_a | s1_b);
            OP_PASS: alu_res = s1_a;
            // Bit DATA_W of the widened difference is the borrow (A < B).
            OP_SUB:  {alu_carry, alu_res} = {1'b0, s1_a} - {1'b0, s1_b};
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (s1_a < s1_b)};
            default: alu_res = '0;
        endcase
    end

    // Result that enters S2 (and the register file) on the next advance.
    logic [DATA_W-1:0] res_next;
    logic              carry_next;

    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        case (s1_mc)
            MC_NONE: begin
                res_next   = '0;
                carry_next = 1'b0;
            end
            MC_LOAD: begin
                res_next   = s1_imm;
                carry_next = 1'b0;
            end
            default: begin
                res_next   = alu_res;
                carry_next = alu_carry;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand read with bypass. A newly accepted instruction samples the
    // register file on the same edge that the older instruction writes it,
    // so a matching write must be forwarded or the old value would be seen.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign rd_a = (wb_en && (s1_mb == op1_in)) ? res_next : regs[op1_in];
    assign rd_b = (wb_en && (s1_mb == op2_in)) ? res_next : regs[op2_in];

    // ------------------------------------------------------------------
    // S1: decoded fields and captured operands
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_mc    <= '0;
            s1_aluc  <= '0;
            s1_mb    <= '0;
            s1_imm   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_mc    <= mc_in;
            s1_aluc  <= aluc_in;
            s1_mb    <= mb_in;
            s1_imm   <= imm_in;
            s1_a     <= rd_a;
            s1_b     <= rd_b;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // S2: result register and flags; held while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RESULTADO <= '0;
            CERO      <= 1'b0;
            ACARREO   <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (advance) begin
            if (s1_valid) begin
                RESULTADO <= res_next;
                CERO      <= (res_next == '0);
                ACARREO   <= carry_next;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file: single write port, written once per instruction on
    // the edge its result enters S2.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[s1_mb] <= res_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chocorrol_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_chocorrol_pipe
// Description : Self-checking bench for chocorrol_pipe. A sequential
//               instruction-level model executes each accepted instruction
//               and queues its expected result; every delivered result is
//               compared against the queue head. A second instance with
//               DATA_W=16 covers the narrow-datapath carry case.
// Revision    : 1.0  initial release
// ============================================================================
module tb_chocorrol_pipe;

    localparam int IW = 20;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] instr;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   resultado;
    logic          out_valid;
    logic          out_ready;
    logic          cero;
    logic          acarreo;

    logic [IW-1:0] instr16;
    logic          in_valid16;
    logic          in_ready16;
    logic [15:0]   resultado16;
    logic          out_valid16;
    logic          out_ready16;
    logic          cero16;
    logic          acarreo16;

    chocorrol_pipe #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK(clk), .RST_N(rst_n), .INSTRUCCION(instr), .IN_VALID(in_valid),
        .IN_READY(in_ready), .RESULTADO(resultado), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .CERO(cero), .ACARREO(acarreo)
    );

    chocorrol_pipe #(.DATA_W(16), .ADDR_W(5)) dut16 (
        .CLK(clk), .RST_N(rst_n), .INSTRUCCION(instr16), .IN_VALID(in_valid16),
        .IN_READY(in_ready16), .RESULTADO(resultado16), .OUT_VALID(out_valid16),
        .OUT_READY(out_ready16), .CERO(cero16), .ACARREO(acarreo16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        longint unsigned res;
        logic            z;
        logic            c;
    } exp_t;

    exp_t            exp_q[$];
    longint unsigned mregs[32];

    logic            acc;
    logic            ov_s;
    longint unsigned last_res;
    logic            last_z;
    logic            last_c;
    int              sent;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [IW-1:0] enc(input logic [1:0] mc, input logic [4:0] op1,
                                          input logic [2:0] aluc, input logic [4:0] op2,
                                          input logic [4:0] mb);
        return {mc, op1, aluc, op2, mb};
    endfunction

    // MC=01 load: the 13-bit immediate occupies the {OP1,ALUC,OP2} fields.
    function automatic logic [IW-1:0] ld(input logic [4:0] mb, input logic [12:0] v);
        return {2'b01, v, mb};
    endfunction

    // Instruction-level reference: executes one instruction against the
    // architectural register model in program order.
    task automatic model_exec(input logic [IW-1:0] ins);
        logic [1:0]      mc;
        logic [2:0]      aluc;
        int              op1, op2, mb;
        longint unsigned a, b, r, c, mask;
        exp_t            e;
        mc   = ins[19:18];
        op1  = int'(ins[17:13]);
        aluc = ins[12:10];
        op2  = int'(ins[9:5]);
        mb   = int'(ins[4:0]);
        mask = 64'h0000_0000_FFFF_FFFF;
        a    = mregs[op1];
        b    = mregs[op2];
        c    = 0;
        case (aluc)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin r = a + b; c = r >> 32; r = r & mask; end
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b) & mask;
            3'd5: r = a;
            3'd6: begin r = (a - b) & mask; c = (a < b) ? 1 : 0; end
            default: r = (a < b) ? 1 : 0;
        endcase
        if (mc == 2'b00) begin
            r = 0; c = 0;
        end else if (mc == 2'b01) begin
            r = 64'(ins[17:5]); c = 0;
        end
        if (mc == 2'b01 || mc == 2'b10) mregs[mb] = r;
        e.res = r;
        e.z   = (r == 0);
        e.c   = c[0];
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // then let the rising edge happen and return at the next falling edge.
    task automatic step(input logic v, input logic [IW-1:0] ins, input logic ordy,
                        output logic accepted);
        exp_t e;
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        #1;
        accepted = v && in_ready;
        ov_s     = out_valid;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q[0];
                check("result", 64'(resultado), e.res);
                check("cero", 64'(cero), 64'(e.z));
                check("acarreo", 64'(acarreo), 64'(e.c));
                if (ordy) begin
                    last_res = 64'(resultado);
                    last_z   = cero;
                    last_c   = acarreo;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (accepted) model_exec(ins);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one instruction, drain the pipe and check the delivered value.
    task automatic run1(input string tag, input logic [IW-1:0] ins, input logic [63:0] expv);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 10) begin
            step(1'b1, ins, 1'b1, a);
            n++;
        end
        check({tag, "_accept"}, 64'(a), 64'(1));
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step(1'b0, '0, 1'b1, a);
            n++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        check(tag, last_res, expv);
    endtask

    task automatic drain(input string tag);
        logic a;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b0, '0, 1'b1, a);
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instr16     = '0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        last_res    = 0;
        last_z      = 1'b0;
        last_c      = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_resultado", 64'(resultado), 64'(0));
        check("rst_cero", 64'(cero), 64'(0));
        check("rst_acarreo", 64'(acarreo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Back-to-back loads and a dependent ADD
        step(1'b1, ld(5'd1, 13'd7), 1'b1, acc);
        check("t1_acc0", 64'(acc), 64'(1));
        step(1'b1, ld(5'd2, 13'd5), 1'b1, acc);
        check("t1_not_yet_valid", 64'(ov_s), 64'(0));
        step(1'b1, enc(2'b10, 5'd1, 3'b010, 5'd2, 5'd3), 1'b1, acc);
        check("t1_first_valid", 64'(ov_s), 64'(1));
        check("t1_r0", last_res, 64'd7);
        step(1'b0, '0, 1'b1, acc);
        check("t1_r1", last_res, 64'd5);
        step(1'b0, '0, 1'b1, acc);
        check("t1_r2", last_res, 64'd12);
        check("t1_cero", 64'(last_z), 64'(0));

        // SUB with borrow, no write-back
        run1("t2_sub", enc(2'b11, 5'd2, 3'b110, 5'd1, 5'd2), 64'hFFFF_FFFE);
        check("t2_carry", 64'(last_c), 64'(1));
        check("t2_cero", 64'(last_z), 64'(0));
        run1("t2_r1_kept", enc(2'b11, 5'd1, 3'b101, 5'd0, 5'd0), 64'd7);
        run1("t2_r2_kept", enc(2'b11, 5'd2, 3'b101, 5'd0, 5'd0), 64'd5);

        // SLT and NOR
        run1("t3_ld1", ld(5'd1, 13'd3), 64'd3);
        run1("t3_ld2", ld(5'd2, 13'd4), 64'd4);
        run1("t3_slt_lt", enc(2'b11, 5'd1, 3'b111, 5'd2, 5'd0), 64'd1);
        run1("t3_slt_ge", enc(2'b11, 5'd2, 3'b111, 5'd1, 5'd0), 64'd0);
        check("t3_slt_cero", 64'(last_z), 64'(1));
        run1("t3_ld1b", ld(5'd1, 13'd2), 64'd2);
        run1("t3_ld2b", ld(5'd2, 13'd1), 64'd1);
        run1("t3_nor", enc(2'b11, 5'd1, 3'b100, 5'd2, 5'd0), 64'hFFFF_FFFC);

        // Backpressure: OUT_READY low for cycles 1..3
        sent = 0;
        for (int cyc = 0; cyc < 30 && (sent < 4 || exp_q.size() != 0); cyc++) begin
            step(sent < 4, ld(5'(8 + sent), 13'(100 + sent)), !(cyc >= 1 && cyc <= 3), acc);
            if (cyc == 2 || cyc == 3) check("bp_in_ready_low", 64'(acc), 64'(0));
            if (acc) sent++;
        end
        check("bp_sent", 64'(sent), 64'(4));
        check("bp_drain", 64'(exp_q.size()), 64'(0));
        run1("bp_r11", enc(2'b11, 5'd11, 3'b101, 5'd0, 5'd0), 64'd103);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 3) != 0, acc);
        end
        drain("rand_drain");

        // Asynchronous reset with two instructions in flight
        step(1'b1, ld(5'd5, 13'd9), 1'b1, acc);
        step(1'b1, ld(5'd6, 13'd3), 1'b1, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_resultado", 64'(resultado), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run1("after_rst_r1", enc(2'b11, 5'd1, 3'b101, 5'd0, 5'd0), 64'd0);
        run1("after_rst_r6", enc(2'b11, 5'd6, 3'b101, 5'd0, 5'd0), 64'd0);

        // DATA_W=16: 0xFFFF + 1 wraps to 0 with carry
        in_valid16 = 1'b1;
        instr16    = ld(5'd1, 13'd1);
        #1;
        check("w16_in_ready", 64'(in_ready16), 64'(1));
        @(posedge clk); @(negedge clk);
        instr16 = enc(2'b10, 5'd0, 3'b110, 5'd1, 5'd2);   // R2 = 0 - 1
        @(posedge clk); @(negedge clk);
        instr16 = enc(2'b11, 5'd2, 3'b010, 5'd1, 5'd0);   // R2 + R1
        #1;
        check("w16_ld", 64'(resultado16), 64'h1);
        @(posedge clk); @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        check("w16_sub", 64'(resultado16), 64'hFFFF);
        check("w16_sub_borrow", 64'(acarreo16), 64'(1));
        @(posedge clk); @(negedge clk);
        #1;
        check("w16_add_valid", 64'(out_valid16), 64'(1));
        check("w16_add", 64'(resultado16), 64'h0);
        check("w16_add_cero", 64'(cero16), 64'(1));
        check("w16_add_carry", 64'(acarreo16), 64'(1));
        @(posedge clk); @(negedge clk);
        #1;
        check("w16_idle", 64'(out_valid16), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
